ex_stage: RTL



---
 rtl/ex_pkg.sv | 57 +++++
 rtl/ex_stage_mul_iter.sv | 97 +++++++++
 rtl/ex_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the RV32 execute stage:
//   - ALUOp encodings coming from the decode stage
//   - funct7 / funct3 constants used by the ALU-control decode
//   - ALU operation enum and iterative-multiplier state enum
//   - arithmetic right-shift helper
// -----------------------------------------------------------------------------
package ex_pkg;

  localparam int XLEN = 32;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SLL,
    ALU_SRA,
    ALU_MUL,
    ALU_NOP
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  // Arithmetic right shift: operand is reinterpreted as signed so the
  // sign bit is replicated into the vacated positions.
  function automatic logic [XLEN-1:0] sra32(input logic [XLEN-1:0] a,
                                            input logic [4:0]      sh);
    logic signed [XLEN-1:0] a_s;
    a_s = a;
    return a_s >>> sh;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
// Iterative 32x32 shift-add multiplier returning the low 32 bits of the
// product (identical for signed and unsigned operands).
//   IDLE -> BUSY : start_i seen; operands captured, cnt cleared
//   BUSY         : one shift-add step per cycle, 32 steps (cnt 0..31)
//   DONE -> IDLE : unconditionally on the next edge; done_o high in DONE
// Ports:
//   clk_i      in   clock, rising edge
//   rst_n      in   synchronous active-low reset (state IDLE, cnt 0)
//   start_i    in   a MUL is present in EX
//   a_i, b_i   in   32-bit operands, sampled only on the IDLE->BUSY edge
//   product_o  out  low 32 bits of a_i*b_i, valid while done_o is high
//   done_o     out  high while the FSM is in DONE
// -----------------------------------------------------------------------------
module mul_iter
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] product_o,
  output logic            done_o
);

  localparam logic [4:0] LAST_STEP = 5'd31;

  mul_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == LAST_STEP) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    done_o    = (state_q == MUL_DONE);
    product_o = acc_q;
  end

  // Datapath: operands are latched once at start so later changes on the
  // forwarding paths cannot disturb a multiply already in flight.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (state_q == MUL_IDLE && start_i) begin
      cnt_d    = 5'd0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Data registers carry no reset; they are always reloaded at start.
  always_ff @(posedge clk_i) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage RV32 pipeline: operand forwarding, ALU
// control decode, ALU and the EX/MEM pipeline register.
// Optional feature macro: EX_MUL_EN builds the iterative multiplier (mul_iter)
// and the MUL stall. Without it, MUL decodes as an unsupported op (result 0).
// Ports:
//   clk_i, rst_n                         clock, synchronous active-low reset
//   RegWrite_i..MemWrite_i, ALUOp_i,     ID/EX control
//   ALUSrc_i
//   rs1_data_i, rs2_data_i, imm_i,       ID/EX operands and function bits
//   func_i
//   rs1_addr_i, rs2_addr_i, rd_addr_i    register addresses
//   wb_RegWrite_i, wb_rd_addr_i,         MEM/WB write-back for forwarding
//   wb_data_i
//   RegWrite_o..MemWrite_o, alu_result_o,
//   store_data_o, rd_addr_o              EX/MEM register outputs
//   stall_o                              combinational; upstream holds when 1
// -----------------------------------------------------------------------------
module ex_stage
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            RegWrite_i,
  input  logic            MemtoReg_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            ALUSrc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [9:0]      func_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            wb_RegWrite_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            RegWrite_o,
  output logic            MemtoReg_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            stall_o
);

  // EX/MEM register
  logic            regwrite_q, regwrite_d;
  logic            memtoreg_q, memtoreg_d;
  logic            memread_q,  memread_d;
  logic            memwrite_q, memwrite_d;
  logic [XLEN-1:0] result_q,   result_d;
  logic [XLEN-1:0] store_q,    store_d;
  logic [4:0]      rd_q,       rd_d;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  alu_ctrl_e       alu_ctrl;
  logic            stall;

  // Forwarding: the younger EX/MEM result has priority over MEM/WB; x0 is
  // never forwarded because it is hard-wired to zero.
  always_comb begin
    fwd_a = rs1_data_i;
    if (regwrite_q && rd_q != 5'd0 && rd_q == rs1_addr_i) begin
      fwd_a = result_q;
    end else if (wb_RegWrite_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == rs1_addr_i) begin
      fwd_a = wb_data_i;
    end

    fwd_b = rs2_data_i;
    if (regwrite_q && rd_q != 5'd0 && rd_q == rs2_addr_i) begin
      fwd_b = result_q;
    end else if (wb_RegWrite_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == rs2_addr_i) begin
      fwd_b = wb_data_i;
    end

    op_b = ALUSrc_i ? imm_i : fwd_b;
  end

  // ALU control decode
  always_comb begin
    alu_ctrl = ALU_NOP;
    case (ALUOp_i)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (func_i)
          {F7_BASE, F3_ADD}:   alu_ctrl = ALU_ADD;
          {F7_ALT,  F3_ADD}:   alu_ctrl = ALU_SUB;
          {F7_BASE, F3_AND}:   alu_ctrl = ALU_AND;
          {F7_BASE, F3_XOR}:   alu_ctrl = ALU_XOR;
          {F7_BASE, F3_SLL}:   alu_ctrl = ALU_SLL;
`ifdef EX_MUL_EN
          {F7_MULDIV, F3_ADD}: alu_ctrl = ALU_MUL;
`endif
          default:             alu_ctrl = ALU_NOP;
        endcase
      end
      ALUOP_ITYPE: begin
        // funct7 bits of an ADDI are immediate bits and must be ignored.
        if (func_i[2:0] == F3_ADD) begin
          alu_ctrl = ALU_ADD;
        end else if (func_i[2:0] == F3_SR && func_i[9:3] == F7_ALT) begin
          alu_ctrl = ALU_SRA;
        end
      end
      default: alu_ctrl = ALU_NOP;
    endcase
  end

`ifdef EX_MUL_EN
  logic            mul_in_ex;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign mul_in_ex = (alu_ctrl == ALU_MUL);

  mul_iter u_mul_iter (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (mul_in_ex),
    .a_i       (fwd_a),
    .b_i       (op_b),
    .product_o (mul_product),
    .done_o    (mul_done)
  );

  // Hold upstream until the product is available in DONE.
  assign stall = mul_in_ex && !mul_done;
`else
  assign stall = 1'b0;
`endif

  // ALU
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_XOR: alu_res = fwd_a ^ op_b;
      ALU_SLL: alu_res = fwd_a << op_b[4:0];
      ALU_SRA: alu_res = sra32(fwd_a, imm_i[4:0]);
`ifdef EX_MUL_EN
      ALU_MUL: alu_res = mul_product;
`endif
      default: alu_res = '0;
    endcase
  end

  // EX/MEM boundary: a stalled cycle loads a bubble (control cleared,
  // datapath fields held).
  always_comb begin
    if (stall) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      result_d   = result_q;
      store_d    = store_q;
      rd_d       = rd_q;
    end else begin
      regwrite_d = RegWrite_i;
      memtoreg_d = MemtoReg_i;
      memread_d  = MemRead_i;
      memwrite_d = MemWrite_i;
      result_d   = alu_res;
      store_d    = fwd_b;
      rd_d       = rd_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= 5'd0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      result_q   <= result_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
    end
  end

  assign RegWrite_o   = regwrite_q;
  assign MemtoReg_o   = memtoreg_q;
  assign MemRead_o    = memread_q;
  assign MemWrite_o   = memwrite_q;
  assign alu_result_o = result_q;
  assign store_data_o = store_q;
  assign rd_addr_o    = rd_q;
  assign stall_o      = stall;

endmodule
